// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory with self-clearing initialisation.
//
// Word-addressed RAM of 2**ADDR_W 32-bit words mapped at byte address BASE_ADDR.
// After reset an INIT phase writes NOP_WORD to every word, one per cycle, with
// busy high. In RUN, program-load writes and fetches share the array.
// Fetches are registered with one cycle of latency. A fetch and a write to the
// same word on the same edge return the old data.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   req      in   fetch request
//   pc       in   fetch byte address
//   stall    in   hold instr/pc_out/valid/fault
//   wr_en    in   program-load write strobe
//   wr_addr  in   program-load byte address
//   wr_data  in   program-load data
//   instr    out  fetched word (NOP_WORD on a fault)
//   pc_out   out  byte address of the word in instr
//   valid    out  instr/pc_out/fault are meaningful
//   fault    out  registered fetch was out of range or misaligned
//   busy     out  memory clear in progress
module instr_fetch_mem #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        valid,
  output logic        fault,
  output logic        busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // Byte span of the array; one extra bit so 4*Depth never wraps.
  localparam logic [32:0] Span = 33'(Depth) << 2;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;

  logic [31:0]         mem [Depth];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;

  // Address decode: offset wraps modulo 2**32, so addresses below BASE_ADDR
  // become huge offsets and fall out of range.
  logic [31:0]         pc_off, wr_off;
  logic                pc_ok, wr_ok;
  logic [ADDR_W-1:0]   pc_idx, wr_idx;

  assign pc_off = pc - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign pc_ok  = ({1'b0, pc_off} < Span) && (pc[1:0] == 2'b00);
  assign wr_ok  = ({1'b0, wr_off} < Span) && (wr_addr[1:0] == 2'b00);
  assign pc_idx = pc_off[ADDR_W+1:2];
  assign wr_idx = wr_off[ADDR_W+1:2];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = wr_data;

    case (state_q)
      StInit: begin
        // Clear sweep; req and wr_en are ignored and outputs keep reset values.
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = NOP_WORD;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = wr_en && wr_ok;
        if (!stall) begin
          valid_d = req;
          if (req) begin
            pc_out_d = pc;
            if (pc_ok) begin
              // Array read sees pre-edge contents, giving read-first behaviour.
              instr_d = mem[pc_idx];
              fault_d = 1'b0;
            end else begin
              instr_d = NOP_WORD;
              fault_d = 1'b1;
            end
          end else begin
            fault_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StInit;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StInit;
      idx_q    <= '0;
      instr_q  <= NOP_WORD;
      pc_out_q <= BASE_ADDR;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  // No reset on the array; while reset is held it rewrites word 0 with
  // NOP_WORD, which the subsequent clear sweep does anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign instr  = instr_q;
  assign pc_out = pc_out_q;
  assign valid  = valid_q;
  assign fault  = fault_q;
  assign busy   = (state_q == StInit);

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] pc;
  logic        stall;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid;
  logic        fault;
  logic        busy;

  instr_fetch_mem #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .NOP_WORD (NOP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .pc     (pc),
    .stall  (stall),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .instr  (instr),
    .pc_out (pc_out),
    .valid  (valid),
    .fault  (fault),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain array plus the four visible output values.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_fault;

  typedef struct {
    string       name;
    bit          rq;
    logic [31:0] p;
    bit          st;
    bit          we;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          e_valid;
    bit          e_fault;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // In range iff BASE <= a < BASE + 4*DEPTH (no wrap) and word aligned.
  function automatic bit m_ok(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * DEPTH) && (a % 4 == 0);
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_instr = NOP;
    m_pc    = BASE;
    m_valid = 1'b0;
    m_fault = 1'b0;
  endtask

  // Drive one RUN cycle and advance the model; returns #1 after the edge.
  task automatic apply(input bit rq, input logic [31:0] p, input bit st, input bit we,
                       input logic [31:0] wa, input logic [31:0] wd);
    @(negedge clk);
    req = rq; pc = p; stall = st; wr_en = we; wr_addr = wa; wr_data = wd;
    if (!st) begin
      m_valid = rq;
      if (rq) begin
        m_pc = p;
        if (m_ok(p)) begin
          m_instr = m_mem[m_idx(p)];
          m_fault = 1'b0;
        end else begin
          m_instr = NOP;
          m_fault = 1'b1;
        end
      end else begin
        m_fault = 1'b0;
      end
    end
    if (we && m_ok(wa)) m_mem[m_idx(wa)] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int edges;
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (!busy) break;
    end
    chk(name, edges, 16);
  endtask

  task automatic add(input string n, input bit rq, input logic [31:0] p, input bit st,
                     input bit we, input logic [31:0] wa, input logic [31:0] wd,
                     input bit ev, input bit ef, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.rq = rq; v.p = p; v.st = st; v.we = we; v.wa = wa; v.wd = wd;
    v.e_valid = ev; v.e_fault = ef; v.e_instr = ei; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic chk_model(input string name);
    chk({name, ".instr"}, instr, m_instr);
    chk({name, ".pc_out"}, pc_out, m_pc);
    chk({name, ".valid"}, 32'(valid), 32'(m_valid));
    chk({name, ".fault"}, 32'(fault), 32'(m_fault));
    chk({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 4 * $urandom_range(0, DEPTH - 1);
    else if (r == 7) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
    else if (r == 8) return BASE - 4 * $urandom_range(1, 3);
    else             return BASE + $urandom_range(0, 4 * DEPTH - 1);
  endfunction

  initial begin
    //            name        rq pc            st we wa            wd             v  f  instr          pc_out
    add("fetch3000",     1, 32'h3000,     0, 0, 32'h0,       32'h0,         1, 0, 32'h0,         32'h3000);
    add("wr3000",        0, 32'h0,        0, 1, 32'h3000,    32'hCAFE_F00D, 0, 0, 32'h0,         32'h3000);
    add("wr303c",        0, 32'h0,        0, 1, 32'h303C,    32'hBEEF_0001, 0, 0, 32'h0,         32'h3000);
    add("wr3004",        0, 32'h0,        0, 1, 32'h3004,    32'h2408_0005, 0, 0, 32'h0,         32'h3000);
    add("fetch3004",     1, 32'h3004,     0, 0, 32'h0,       32'h0,         1, 0, 32'h2408_0005, 32'h3004);
    add("fetch303c",     1, 32'h303C,     0, 0, 32'h0,       32'h0,         1, 0, 32'hBEEF_0001, 32'h303C);
    add("fault3040",     1, 32'h3040,     0, 0, 32'h0,       32'h0,         1, 1, NOP,           32'h3040);
    add("fault2ffc",     1, 32'h2FFC,     0, 0, 32'h0,       32'h0,         1, 1, NOP,           32'h2FFC);
    add("fault3002",     1, 32'h3002,     0, 0, 32'h0,       32'h0,         1, 1, NOP,           32'h3002);
    add("refetch3004",   1, 32'h3004,     0, 0, 32'h0,       32'h0,         1, 0, 32'h2408_0005, 32'h3004);
    add("stall1",        1, 32'h3010,     1, 0, 32'h0,       32'h0,         1, 0, 32'h2408_0005, 32'h3004);
    add("stall2",        0, 32'h3020,     1, 0, 32'h0,       32'h0,         1, 0, 32'h2408_0005, 32'h3004);
    add("stall3_wr",     1, 32'h3040,     1, 1, 32'h3008,    32'h1111_2222, 1, 0, 32'h2408_0005, 32'h3004);
    add("unstall_idle",  0, 32'h3000,     0, 0, 32'h0,       32'h0,         0, 0, 32'h2408_0005, 32'h3004);
    add("fetch3008",     1, 32'h3008,     0, 0, 32'h0,       32'h0,         1, 0, 32'h1111_2222, 32'h3008);
    add("readfirst",     1, 32'h3008,     0, 1, 32'h3008,    32'hAAAA_AAAA, 1, 0, 32'h1111_2222, 32'h3008);
    add("after_rf",      1, 32'h3008,     0, 0, 32'h0,       32'h0,         1, 0, 32'hAAAA_AAAA, 32'h3008);
    add("wr_oor_hi",     0, 32'h0,        0, 1, 32'h3040,    32'h0000_0055, 0, 0, 32'hAAAA_AAAA, 32'h3008);
    add("wr_oor_lo",     0, 32'h0,        0, 1, 32'h2FFC,    32'h0000_0066, 0, 0, 32'hAAAA_AAAA, 32'h3008);
    add("wr_misalign",   0, 32'h0,        0, 1, 32'h3001,    32'h0000_0077, 0, 0, 32'hAAAA_AAAA, 32'h3008);
    add("chk_w0",        1, 32'h3000,     0, 0, 32'h0,       32'h0,         1, 0, 32'hCAFE_F00D, 32'h3000);
    add("chk_w15",       1, 32'h303C,     0, 0, 32'h0,       32'h0,         1, 0, 32'hBEEF_0001, 32'h303C);

    reset = 1'b1; req = 1'b0; pc = '0; stall = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    chk("por.instr", instr, NOP);
    chk("por.pc_out", pc_out, BASE);
    chk("por.valid", 32'(valid), 32'd0);
    chk("por.fault", 32'(fault), 32'd0);
    chk("por.busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);

    // Release, then reset again part-way through the clear.
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // Traffic during INIT must be ignored.
    req = 1'b1; pc = BASE; wr_en = 1'b1; wr_addr = BASE; wr_data = 32'hDEAD_BEEF;
    wait_init("init_len");
    chk("init.valid", 32'(valid), 32'd0);
    chk("init.pc_out", pc_out, BASE);
    model_reset();

    foreach (vecs[i]) begin
      apply(vecs[i].rq, vecs[i].p, vecs[i].st, vecs[i].we, vecs[i].wa, vecs[i].wd);
      chk({vecs[i].name, ".instr"}, instr, vecs[i].e_instr);
      chk({vecs[i].name, ".pc_out"}, pc_out, vecs[i].e_pc);
      chk({vecs[i].name, ".valid"}, 32'(valid), 32'(vecs[i].e_valid));
      chk({vecs[i].name, ".fault"}, 32'(fault), 32'(vecs[i].e_fault));
      chk({vecs[i].name, ".busy"}, 32'(busy), 32'd0);
    end

    for (int c = 0; c < 300; c++) begin
      apply($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, rand_addr(), $urandom);
      chk_model($sformatf("rand%0d", c));
    end

    // Load a known word, then reset mid-RUN between edges.
    apply(0, 32'h0, 0, 1, 32'h3004, 32'h2408_0005);
    apply(1, 32'h3004, 0, 0, 32'h0, 32'h0);
    chk("preload.instr", instr, 32'h2408_0005);
    @(negedge clk);
    req = 1'b0; wr_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst.instr", instr, NOP);
    chk("mid_rst.pc_out", pc_out, BASE);
    chk("mid_rst.valid", 32'(valid), 32'd0);
    chk("mid_rst.fault", 32'(fault), 32'd0);
    chk("mid_rst.busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_init("reinit_len");
    model_reset();
    apply(1, 32'h3004, 0, 0, 32'h0, 32'h0);
    chk("after_clear.instr", instr, 32'h0);
    chk_model("after_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning log2 of the word depth (DEPTH = 2^ADDR_W words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_3000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning the word returned on a faulting fetch.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 1 bit: fetch request.
REQ-007 The block SHALL have port pc, input, 32 bits: fetch byte address.
REQ-008 The block SHALL have port stall, input, 1 bit: hold the output register.
REQ-009 The block SHALL have port wr_en, input, 1 bit: program-load write strobe.
REQ-010 The block SHALL have port wr_addr, input, 32 bits: program-load byte address.
REQ-011 The block SHALL have port wr_data, input, 32 bits: program-load data.
REQ-012 The block SHALL have port instr, output, 32 bits: fetched word.
REQ-013 The block SHALL have port pc_out, output, 32 bits: address of the word in instr.
REQ-014 The block SHALL have port valid, output, 1 bit: instr/pc_out/fault are meaningful.
REQ-015 The block SHALL have port fault, output, 1 bit: address error on the registered fetch.
REQ-016 The block SHALL have port busy, output, 1 bit: memory clear in progress.

Function
REQ-017 The block SHALL implement a two-state FSM, INIT and RUN; reset forces INIT with clear index 0.
REQ-018 In INIT, the block SHALL write NOP_WORD to word[idx] each cycle, idx incrementing 0..DEPTH-1, then enter RUN; INIT lasts exactly DEPTH cycles after reset deasserts.
REQ-019 busy SHALL equal 1 exactly while in INIT.
REQ-020 In INIT, req and wr_en SHALL be ignored, and the output registers SHALL hold their reset values.
REQ-021 Address decode SHALL be: off = addr - BASE_ADDR, 32-bit unsigned with wrap; the address is in range iff off < 4*DEPTH and addr[1:0] == 0; word index = off[ADDR_W+1:2].
REQ-022 In RUN, when wr_en=1 and wr_addr is in range, the block SHALL write wr_data to the word at that index on the clock edge; an out-of-range wr_addr SHALL be silently dropped.
REQ-023 In RUN with stall=0 and req=1, the next edge SHALL load valid=1 and pc_out=pc; an in-range pc SHALL load instr=word[index] and fault=0; an out-of-range or misaligned pc SHALL load instr=NOP_WORD and fault=1.
REQ-024 Read latency SHALL be one cycle, with pc sampled on the edge and instr valid after it.
REQ-025 In RUN with stall=0 and req=0, the next edge SHALL load valid=0 and fault=0, with instr and pc_out held.
REQ-026 With stall=1, instr, pc_out, valid and fault SHALL all hold regardless of req; writes SHALL still occur.
REQ-027 When a fetch and a write target the same word on the same edge, the fetch SHALL return the old data (read-first), and the new data SHALL be visible from the next fetch.
REQ-028 pc = BASE_ADDR + 4*DEPTH - 4 SHALL be in range; BASE_ADDR + 4*DEPTH and BASE_ADDR - 4 SHALL both fault.

Reset
REQ-029 On reset assertion, the block SHALL immediately set instr=NOP_WORD, pc_out=BASE_ADDR, valid=0, fault=0, busy=1, state INIT and clear index 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the clear from index 0; memory contents SHALL be treated as undefined until busy falls.

Verification
REQ-031 Verification SHALL cover the INIT timing case: ADDR_W=4, release reset -> busy=1 for exactly 16 edges, then 0; a fetch at 32'h3000 returns 0 with fault=0.
REQ-032 Verification SHALL cover the load-then-fetch case: write 32'h2408_0005 to 32'h3004, then on the next cycle req with pc=32'h3004 -> one edge later instr=32'h2408_0005, pc_out=32'h3004, valid=1.
REQ-033 Verification SHALL cover the fault case: ADDR_W=4, fetches at 32'h303C, 32'h3040, 32'h2FFC and 32'h3002 -> fault = 0, 1, 1, 1; instr=NOP_WORD on each fault.
REQ-034 Verification SHALL cover the stall case: valid fetch of 32'h3004, then stall=1 for 3 cycles while pc changes -> instr and pc_out unchanged, valid stays 1; after stall=0 with req=0 -> valid=0.
REQ-035 Verification SHALL cover the read-first case: same edge write 32'hAAAA_AAAA to 32'h3008 and fetch 32'h3008 -> old value returned; the next fetch returns 32'hAAAA_AAAA.
REQ-036 Verification SHALL cover the mid-operation reset case: assert reset during RUN after loads -> outputs take reset values immediately, busy=1, and the loaded word reads 0 after the re-clear.
